// File: rtl/axi4_burst_memory_slave.sv
// AXI4 memory slave with FIXED/INCR/WRAP bursts, byte strobes and SLVERR reporting.
// Write and read channels run as independent FSMs sharing one internal array.
module axi4_burst_memory_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_WIDTH - BYTE_SH;
  localparam int MEM_AW  = $clog2(MEM_DEPTH);
  localparam logic [IDX_W:0] DEPTH_L = MEM_DEPTH[IDX_W:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_L;
  endfunction

  // Legal WRAP keeps the bits above the LEN mask and wraps the low bits.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [7:0] len,
                                                input logic [1:0] burst);
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] inc;
    mask = {{(IDX_W-8){1'b0}}, len};
    inc  = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    case (burst)
      BURST_FIXED: next_idx = idx;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) next_idx = (idx & ~mask) | (inc & mask);
        else                  next_idx = inc;
      end
      default: next_idx = inc;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wstate_t             r_wstate, w_wstate_nxt;
  logic                r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0] r_awid, r_bid;
  logic [1:0]          r_bresp, r_awburst;
  logic [IDX_W-1:0]    r_widx;
  logic [7:0]          r_awlen, r_wcnt;
  logic                r_werr;

  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_arid, r_rid;
  logic [1:0]            r_rresp, r_arburst;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W-1:0]      r_ridx;
  logic [7:0]            r_arlen, r_rcnt;
  logic                  r_rerr;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_wlast_beat, w_beat_err, w_mem_we;
  logic w_unused_addr_bits;

  assign w_aw_hs      = i_awvalid & r_awready;
  assign w_w_hs       = i_wvalid & r_wready;
  assign w_b_hs       = r_bvalid & i_bready;
  assign w_ar_hs      = i_arvalid & r_arready;
  assign w_r_hs       = r_rvalid & i_rready;
  assign w_wlast_beat = (r_wcnt == r_awlen);
  assign w_beat_err   = !in_range(r_widx) || (i_wlast != w_wlast_beat);
  assign w_mem_we     = w_w_hs & in_range(r_widx) & ~i_areset;
  assign w_unused_addr_bits = ^{i_awaddr[BYTE_SH-1:0], i_araddr[BYTE_SH-1:0]};

  // Write FSM state register
  always_ff @(posedge i_aclk) begin
    if (i_areset) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM next-state logic; the burst ends at beat AWLEN whatever WLAST says
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) w_wstate_nxt = W_DATA;
        else         w_wstate_nxt = W_IDLE;
      end
      W_DATA: begin
        if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
        else                        w_wstate_nxt = W_DATA;
      end
      W_RESP: begin
        if (w_b_hs) w_wstate_nxt = W_IDLE;
        else        w_wstate_nxt = W_RESP;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel datapath and registered handshake outputs
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= {ID_WIDTH{1'b0}};
      r_bresp   <= RESP_OKAY;
      r_awid    <= {ID_WIDTH{1'b0}};
      r_awburst <= 2'b00;
      r_widx    <= {IDX_W{1'b0}};
      r_awlen   <= 8'd0;
      r_wcnt    <= 8'd0;
      r_werr    <= 1'b0;
    end else begin
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_awid    <= i_awid;
        r_widx    <= i_awaddr[ADDR_WIDTH-1:BYTE_SH];
        r_awlen   <= i_awlen;
        r_awburst <= i_awburst;
        r_wcnt    <= 8'd0;
        r_werr    <= burst_err(i_awburst, i_awlen);
      end else if (w_w_hs) begin
        r_widx <= next_idx(r_widx, r_awlen, r_awburst);
        r_wcnt <= r_wcnt + 8'd1;
        r_werr <= r_werr | w_beat_err;
        if (w_wlast_beat) begin
          r_bid   <= r_awid;
          r_bresp <= (r_werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-enabled array write; contents are never reset
  always_ff @(posedge i_aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[r_widx[MEM_AW-1:0]][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge i_aclk) begin
    if (i_areset) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read FSM next-state logic
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) w_rstate_nxt = R_FETCH;
        else         w_rstate_nxt = R_IDLE;
      end
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA: begin
        if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
        else if (w_r_hs)       w_rstate_nxt = R_FETCH;
        else                   w_rstate_nxt = R_DATA;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read channel datapath; the array read in R_FETCH sees pre-write data
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= {ID_WIDTH{1'b0}};
      r_rresp   <= RESP_OKAY;
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_arid    <= {ID_WIDTH{1'b0}};
      r_arburst <= 2'b00;
      r_ridx    <= {IDX_W{1'b0}};
      r_arlen   <= 8'd0;
      r_rcnt    <= 8'd0;
      r_rerr    <= 1'b0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_arid    <= i_arid;
        r_ridx    <= i_araddr[ADDR_WIDTH-1:BYTE_SH];
        r_arlen   <= i_arlen;
        r_arburst <= i_arburst;
        r_rcnt    <= 8'd0;
        r_rerr    <= burst_err(i_arburst, i_arlen);
      end else if (r_rstate == R_FETCH) begin
        r_rid   <= r_arid;
        r_rlast <= (r_rcnt == r_arlen);
        if (in_range(r_ridx)) begin
          r_rdata <= r_mem[r_ridx[MEM_AW-1:0]];
          r_rresp <= r_rerr ? RESP_SLVERR : RESP_OKAY;
        end else begin
          r_rdata <= {DATA_WIDTH{1'b0}};
          r_rresp <= RESP_SLVERR;
        end
      end else if (w_r_hs && !r_rlast) begin
        r_ridx <= next_idx(r_ridx, r_arlen, r_arburst);
        r_rcnt <= r_rcnt + 8'd1;
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;

endmodule
